// File: rtl/ysyx_22041071_axi_r_burst.sv
// CPU line read -> one AXI4 INCR read burst, assembled into a line buffer and returned with a merged response.
// Define YSYX_22041071_AXI_R_TIMEOUT_EN to add a stall watchdog that forces an error response.
module ysyx_22041071_axi_r_burst #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int ID_W      = 4,
  parameter int MAX_BEATS = 8,
  parameter int TIMEOUT   = 256
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ID_W-1:0]             req_id,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [7:0]                  req_len,
  input  logic [2:0]                  req_size,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W*MAX_BEATS-1:0] rsp_data,
  output logic [1:0]                  rsp_resp,
  output logic                        axi_ar_valid,
  input  logic                        axi_ar_ready,
  output logic [ID_W-1:0]             axi_ar_id,
  output logic [ADDR_W-1:0]           axi_ar_addr,
  output logic [7:0]                  axi_ar_len,
  output logic [2:0]                  axi_ar_size,
  output logic [1:0]                  axi_ar_burst,
  output logic [2:0]                  axi_ar_prot,
  output logic [3:0]                  axi_ar_cache,
  output logic [3:0]                  axi_ar_qos,
  output logic [3:0]                  axi_ar_region,
  output logic                        axi_ar_lock,
  input  logic                        axi_r_valid,
  output logic                        axi_r_ready,
  input  logic [DATA_W-1:0]           axi_r_data,
  input  logic [1:0]                  axi_r_resp,
  input  logic                        axi_r_last,
  input  logic [ID_W-1:0]             axi_r_id
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int CNT_W = 9;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   beat_cnt;
  logic [OFF_W-1:0]   cap_off;
  logic [2:0]         cap_size;
  logic [DATA_W-1:0]  beat_data;
  logic [DATA_W-1:0]  size_mask;
  logic [1:0]         merged_resp;
  logic               beat_err;
  logic               len_too_long;
  logic               wd_expire;

  assign req_ready     = (state == IDLE);
  assign axi_ar_valid  = (state == ADDR);
  assign axi_r_ready   = (state == DATA);
  assign rsp_valid     = (state == RESP);
  assign axi_ar_prot   = '0;
  assign axi_ar_cache  = '0;
  assign axi_ar_qos    = '0;
  assign axi_ar_region = '0;
  assign axi_ar_lock   = 1'b0;

  assign len_too_long = ({1'b0, req_len} >= CNT_W'(MAX_BEATS));
  assign beat_err = (axi_r_id != axi_ar_id)
                 || ( axi_r_last && (beat_cnt <  {1'b0, axi_ar_len}))
                 || (!axi_r_last && (beat_cnt >= {1'b0, axi_ar_len}));

  // NOTE: every variable of an always_comb is assigned before any condition so no latch is inferred.
  always_comb begin
    for (int i = 0; i < BYTES; i++)
      size_mask[i*8 +: 8] = (i < (1 << cap_size)) ? 8'hFF : 8'h00;
    // A single narrow beat is returned right-aligned and trimmed to its transfer size.
    beat_data = axi_r_data;
    if (axi_ar_len == 8'd0)
      beat_data = (axi_r_data >> {cap_off, 3'b000}) & size_mask;
    merged_resp = (axi_r_resp > rsp_resp) ? axi_r_resp : rsp_resp;
    if (beat_err && (merged_resp < 2'b10))
      merged_resp = 2'b10;
  end

`ifdef YSYX_22041071_AXI_R_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_expire = (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset_n)
      wd_cnt <= '0;
    else if ((state == ADDR && !axi_ar_ready) || (state == DATA && !axi_r_valid))
      wd_cnt <= wd_expire ? '0 : wd_cnt + 1'b1;
    else
      wd_cnt <= '0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign wd_expire      = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      // NOTE: the line buffer is plain flops, not a RAM, so resetting it is legal and cheap to reason about.
      rsp_data     <= '0;
      rsp_resp     <= '0;
      axi_ar_id    <= '0;
      axi_ar_addr  <= '0;
      axi_ar_len   <= '0;
      axi_ar_size  <= '0;
      axi_ar_burst <= '0;
      cap_off      <= '0;
      cap_size     <= '0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          axi_ar_id    <= req_id;
          axi_ar_addr  <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
          axi_ar_len   <= req_len;
          axi_ar_size  <= (req_len == 8'd0) ? req_size : 3'(OFF_W);
          axi_ar_burst <= 2'b01;
          cap_off      <= req_addr[OFF_W-1:0];
          cap_size     <= req_size;
          rsp_data     <= '0;
          if (len_too_long) begin
            state    <= RESP;
            rsp_resp <= 2'b10;
          end else begin
            state    <= ADDR;
            rsp_resp <= 2'b00;
          end
        end
        ADDR: if (axi_ar_ready) begin
          state    <= DATA;
          beat_cnt <= '0;
          rsp_data <= '0;
          rsp_resp <= 2'b00;
        end else if (wd_expire) begin
          state    <= RESP;
          rsp_resp <= 2'b11;
        end
        DATA: if (axi_r_valid) begin
          // Beats past the last slot are still handshaken but dropped.
          for (int k = 0; k < MAX_BEATS; k++)
            if (beat_cnt == CNT_W'(k))
              rsp_data[k*DATA_W +: DATA_W] <= beat_data;
          if (beat_cnt != '1)
            beat_cnt <= beat_cnt + 1'b1;
          rsp_resp <= merged_resp;
          if (axi_r_last)
            state <= RESP;
        end else if (wd_expire) begin
          state    <= RESP;
          rsp_resp <= 2'b11;
        end
        RESP: if (rsp_ready)
          state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_axi_r_burst.sv
// Directed bench for ysyx_22041071_axi_r_burst: single beat, burst latency, protocol errors, backpressure, watchdog, reset.
module tb_ysyx_22041071_axi_r_burst;
  localparam int DW = 64;
  localparam int AW = 64;
  localparam int IW = 4;
  localparam int MB = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req_valid, req_ready;
  logic [IW-1:0]     req_id;
  logic [AW-1:0]     req_addr;
  logic [7:0]        req_len;
  logic [2:0]        req_size;
  logic              rsp_valid, rsp_ready;
  logic [DW*MB-1:0]  rsp_data;
  logic [1:0]        rsp_resp;
  logic              axi_ar_valid, axi_ar_ready;
  logic [IW-1:0]     axi_ar_id;
  logic [AW-1:0]     axi_ar_addr;
  logic [7:0]        axi_ar_len;
  logic [2:0]        axi_ar_size;
  logic [1:0]        axi_ar_burst;
  logic [2:0]        axi_ar_prot;
  logic [3:0]        axi_ar_cache, axi_ar_qos, axi_ar_region;
  logic              axi_ar_lock;
  logic              axi_r_valid, axi_r_ready;
  logic [DW-1:0]     axi_r_data;
  logic [1:0]        axi_r_resp;
  logic              axi_r_last;
  logic [IW-1:0]     axi_r_id;

  int passed = 0;
  int total  = 0;

  ysyx_22041071_axi_r_burst #(
    .DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .MAX_BEATS(MB), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_addr(req_addr),
    .req_len(req_len), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_id(axi_ar_id),
    .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size),
    .axi_ar_burst(axi_ar_burst), .axi_ar_prot(axi_ar_prot), .axi_ar_cache(axi_ar_cache),
    .axi_ar_qos(axi_ar_qos), .axi_ar_region(axi_ar_region), .axi_ar_lock(axi_ar_lock),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_data(axi_r_data),
    .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last), .axi_r_id(axi_r_id)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] beat(input int k);
    return rsp_data[k*DW +: DW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                       input logic [7:0] len, input logic [2:0] size);
    req_id = id; req_addr = addr; req_len = len; req_size = size; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [1:0] resp,
                           input logic last, input logic [IW-1:0] id);
    axi_r_valid = 1'b1; axi_r_data = d; axi_r_resp = resp; axi_r_last = last; axi_r_id = id;
    step();
    axi_r_valid = 1'b0; axi_r_last = 1'b0;
  endtask

  task automatic ar_accept();
    axi_ar_ready = 1'b1;
    step();
    axi_ar_ready = 1'b0;
  endtask

  task automatic rsp_accept();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = 0; req_id = 0; req_addr = 0; req_len = 0; req_size = 0; rsp_ready = 0;
    axi_ar_ready = 0; axi_r_valid = 0; axi_r_data = 0; axi_r_resp = 0; axi_r_last = 0; axi_r_id = 0;
    step(); step();
    reset_n = 1'b1;
    total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b expected 1", req_ready); else passed++;
    total++; if ({axi_ar_valid, axi_r_ready, rsp_valid} !== 3'b000)
      $display("FAIL rst_valids: got %b expected 000", {axi_ar_valid, axi_r_ready, rsp_valid}); else passed++;
    total++; if (rsp_data !== '0) $display("FAIL rst_rsp_data: got %0h expected 0", rsp_data); else passed++;
    total++; if ({rsp_resp, axi_ar_addr, axi_ar_len, axi_ar_burst} !== '0)
      $display("FAIL rst_regs: got resp=%0h addr=%0h len=%0h burst=%0h expected 0", rsp_resp, axi_ar_addr, axi_ar_len, axi_ar_burst);
    else passed++;
  endtask

  task automatic test_single_beat();
    issue(4'h3, 64'h8000_0005, 8'd0, 3'd0);
    total++; if (axi_ar_valid !== 1'b1) $display("FAIL sb_ar_valid: got %b expected 1", axi_ar_valid); else passed++;
    total++; if (axi_ar_addr !== 64'h8000_0000) $display("FAIL sb_araddr: got %0h expected 80000000", axi_ar_addr); else passed++;
    total++; if ({axi_ar_size, axi_ar_len, axi_ar_burst, axi_ar_id} !== {3'd0, 8'd0, 2'b01, 4'h3})
      $display("FAIL sb_ar_payload: got size=%0d len=%0d burst=%0d id=%0h expected 0 0 1 3", axi_ar_size, axi_ar_len, axi_ar_burst, axi_ar_id);
    else passed++;
    total++; if ({axi_ar_prot, axi_ar_cache, axi_ar_qos, axi_ar_region, axi_ar_lock} !== '0)
      $display("FAIL sb_ar_const: got nonzero attributes, expected 0"); else passed++;
    ar_accept();
    total++; if ({axi_ar_valid, axi_r_ready} !== 2'b01) $display("FAIL sb_data_state: got %b expected 01", {axi_ar_valid, axi_r_ready}); else passed++;
    send_beat(64'h1122_3344_5566_7788, 2'b00, 1'b1, 4'h3);
    total++; if (rsp_valid !== 1'b1) $display("FAIL sb_rsp_valid: got %b expected 1", rsp_valid); else passed++;
    total++; if (beat(0) !== 64'h33) $display("FAIL sb_rsp_data: got %0h expected 33", beat(0)); else passed++;
    total++; if (rsp_resp !== 2'b00) $display("FAIL sb_rsp_resp: got %0d expected 0", rsp_resp); else passed++;
    rsp_accept();
    total++; if (req_ready !== 1'b1) $display("FAIL sb_back_idle: got %b expected 1", req_ready); else passed++;
  endtask

  task automatic test_burst();
    int early_valid = 0;
    issue(4'h5, 64'h8000_1000, 8'd7, 3'd2);
    total++; if ({axi_ar_len, axi_ar_size} !== {8'd7, 3'd3})
      $display("FAIL burst_ar: got len=%0d size=%0d expected 7 3", axi_ar_len, axi_ar_size); else passed++;
    ar_accept();
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid !== 1'b0) early_valid++;
      send_beat(64'(k + 'hA0), 2'b00, (k == 7), 4'h5);
    end
    total++; if (early_valid !== 0) $display("FAIL burst_early_rsp: got %0d cycles expected 0", early_valid); else passed++;
    total++; if (rsp_valid !== 1'b1) $display("FAIL burst_latency9: got %b expected 1", rsp_valid); else passed++;
    for (int k = 0; k < 8; k++) begin
      total++; if (beat(k) !== 64'(k + 'hA0)) $display("FAIL burst_beat%0d: got %0h expected %0h", k, beat(k), k + 'hA0); else passed++;
    end
    total++; if (rsp_resp !== 2'b00) $display("FAIL burst_resp: got %0d expected 0", rsp_resp); else passed++;
    rsp_accept();
  endtask

  task automatic test_last_early();
    issue(4'h1, 64'h100, 8'd7, 3'd3);
    ar_accept();
    for (int k = 0; k < 4; k++) send_beat(64'(k + 'h10), 2'b00, (k == 3), 4'h1);
    total++; if (rsp_valid !== 1'b1) $display("FAIL early_last_rsp_valid: got %b expected 1", rsp_valid); else passed++;
    total++; if (rsp_resp !== 2'b10) $display("FAIL early_last_resp: got %0d expected 2", rsp_resp); else passed++;
    total++; if ({beat(3), beat(4)} !== {64'h13, 64'h0})
      $display("FAIL early_last_data: got %0h %0h expected 13 0", beat(3), beat(4)); else passed++;
    rsp_accept();
  endtask

  task automatic test_missing_last();
    issue(4'h2, 64'h200, 8'd1, 3'd3);
    ar_accept();
    send_beat(64'hAA, 2'b00, 1'b0, 4'h2);
    send_beat(64'hBB, 2'b00, 1'b0, 4'h2);
    total++; if (axi_r_ready !== 1'b1) $display("FAIL nolast_still_data: got %b expected 1", axi_r_ready); else passed++;
    send_beat(64'hCC, 2'b01, 1'b1, 4'h2);
    total++; if (rsp_resp !== 2'b10) $display("FAIL nolast_resp: got %0d expected 2", rsp_resp); else passed++;
    total++; if (beat(2) !== 64'hCC) $display("FAIL nolast_beat2: got %0h expected cc", beat(2)); else passed++;
    rsp_accept();
  endtask

  task automatic test_len_overflow();
    issue(4'h4, 64'h300, 8'd8, 3'd3);
    total++; if ({axi_ar_valid, rsp_valid} !== 2'b01)
      $display("FAIL ovf_state: got ar_valid=%b rsp_valid=%b expected 0 1", axi_ar_valid, rsp_valid); else passed++;
    total++; if (rsp_resp !== 2'b10) $display("FAIL ovf_resp: got %0d expected 2", rsp_resp); else passed++;
    rsp_accept();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    issue(4'h6, 64'h400, 8'd1, 3'd3);
    ar_accept();
    send_beat(64'hDEAD_BEEF, 2'b01, 1'b0, 4'h6);
    send_beat(64'hCAFE_F00D, 2'b00, 1'b1, 4'h7);
    for (int c = 0; c < 5; c++) begin
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_resp !== 2'b10 ||
          beat(0) !== 64'hDEAD_BEEF || beat(1) !== 64'hCAFE_F00D) bad++;
      step();
    end
    total++; if (bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); else passed++;
    total++; if (rsp_resp !== 2'b10) $display("FAIL bp_resp: got %0d expected 2", rsp_resp); else passed++;
    rsp_accept();
    total++; if ({req_ready, rsp_valid} !== 2'b10)
      $display("FAIL bp_release: got req_ready=%b rsp_valid=%b expected 1 0", req_ready, rsp_valid); else passed++;
  endtask

  task automatic test_timeout();
    issue(4'h8, 64'h500, 8'd0, 3'd3);
`ifdef YSYX_22041071_AXI_R_TIMEOUT_EN
    for (int c = 0; c < 15; c++) step();
    total++; if (axi_ar_valid !== 1'b1) $display("FAIL to_before: got %b expected 1", axi_ar_valid); else passed++;
    step();
    total++; if ({axi_ar_valid, rsp_valid, rsp_resp} !== 4'b0111)
      $display("FAIL to_fire: got ar=%b rsp=%b resp=%0d expected 0 1 3", axi_ar_valid, rsp_valid, rsp_resp); else passed++;
    rsp_accept();
`else
    for (int c = 0; c < 40; c++) step();
    total++; if ({axi_ar_valid, rsp_valid} !== 2'b10)
      $display("FAIL to_wait: got ar=%b rsp=%b expected 1 0", axi_ar_valid, rsp_valid); else passed++;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
`endif
    total++; if (req_ready !== 1'b1) $display("FAIL to_recover: got %b expected 1", req_ready); else passed++;
  endtask

  task automatic test_reset_mid();
    issue(4'h9, 64'h600, 8'd7, 3'd3);
    ar_accept();
    send_beat(64'h1, 2'b00, 1'b0, 4'h9);
    send_beat(64'h2, 2'b00, 1'b0, 4'h9);
    axi_r_valid = 1'b1; axi_r_data = 64'h3; axi_r_id = 4'h9;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    axi_r_valid = 1'b0;
    total++; if ({req_ready, rsp_valid} !== 2'b10)
      $display("FAIL rm_state: got req_ready=%b rsp_valid=%b expected 1 0", req_ready, rsp_valid); else passed++;
    total++; if (rsp_data !== '0) $display("FAIL rm_data: got %0h expected 0", rsp_data); else passed++;
    step();
    total++; if ({axi_ar_valid, axi_r_ready, req_ready} !== 3'b001)
      $display("FAIL rm_after: got %b expected 001", {axi_ar_valid, axi_r_ready, req_ready}); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_burst();
    test_last_early();
    test_missing_last();
    test_len_overflow();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no completion expected finish");
    $fatal(1);
  end
endmodule

// File: doc/ysyx_22041071_axi_r_burst.md
YSYX_22041071_AXI_R_BURST -- requirements
Module: ysyx_22041071_axi_r_burst

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning the AXI data width in bits (power of 2, >=32).
REQ-002 SHALL have parameter ADDR_W, default 64, meaning the address width.
REQ-003 SHALL have parameter ID_W, default 4, meaning the AXI ID width.
REQ-004 SHALL have parameter MAX_BEATS, default 8, meaning the line-buffer depth in beats (power of 2, 1..256).
REQ-005 SHALL have parameter TIMEOUT, default 256, meaning the watchdog limit in cycles.
REQ-006 clk  in  1  clock; all logic on its rising edge.
REQ-007 reset_n  in  1  reset; synchronous, active-low.
REQ-008 req_valid/req_ready  in/out  1/1  CPU request handshake.
REQ-009 req_id, req_addr, req_len, req_size  in  ID_W/ADDR_W/8/3  ID, byte address, beats-1, AXI size code.
REQ-010 rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-011 rsp_data, rsp_resp  out  DATA_W*MAX_BEATS/2  line data (beat k at bits [k*DATA_W +: DATA_W]), merged response.
REQ-012 axi_ar_valid/axi_ar_ready  out/in  1/1  AR handshake.
REQ-013 axi_ar_id, axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_burst  out  ID_W/ADDR_W/8/3/2  AR payload.
REQ-014 axi_ar_prot, axi_ar_cache, axi_ar_qos, axi_ar_region, axi_ar_lock  out  3/4/4/4/1  constant 0.
REQ-015 axi_r_valid/axi_r_ready  in/out  1/1  R handshake.
REQ-016 axi_r_data, axi_r_resp, axi_r_last, axi_r_id  in  DATA_W/2/1/ID_W  R payload.

Function
REQ-017 FSM SHALL have states IDLE, ADDR, DATA, RESP; req_ready=1 only in IDLE; axi_ar_valid=1 only in ADDR; axi_r_ready=1 only in DATA; rsp_valid=1 only in RESP.
REQ-018 On req_valid&req_ready, all request fields SHALL be registered; next state is ADDR, or RESP with rsp_resp=2'b10 and no AR issued when req_len>=MAX_BEATS.
REQ-019 AR payload SHALL hold constant while in ADDR: id=captured id; addr=captured addr with its low log2(DATA_W/8) bits cleared; len=captured len; burst=INCR; size=captured size when len==0, else log2(DATA_W/8).
REQ-020 ADDR->DATA on AR handshake; beat counter cleared and rsp_data cleared to 0 on entry.
REQ-021 Each R handshake SHALL write axi_r_data into beat slot beat_cnt and increment beat_cnt; handshakes beyond slot MAX_BEATS-1 are accepted and discarded.
REQ-022 rsp_resp SHALL be the maximum axi_r_resp over all beats; an axi_r_id mismatch, an axi_r_last before beat len, or a beat after beat len without axi_r_last SHALL raise rsp_resp to at least 2'b10.
REQ-023 DATA->RESP on the R handshake carrying axi_r_last; rsp_valid is asserted the following cycle (AR handshake to rsp_valid minimum latency = len+2 cycles with zero-wait slave).
REQ-024 Single-beat request (len==0): slot 0 SHALL hold the beat shifted right by 8*(addr mod DATA_W/8) bits, zero-masked to 2^size bytes.
REQ-025 RESP holds rsp_data/rsp_resp stable until rsp_ready; RESP->IDLE on rsp_valid&rsp_ready; a new request may be accepted the cycle after.
REQ-026 AR and R handshakes in the same cycle cannot occur; R beats presented while not in DATA SHALL be stalled (axi_r_ready=0).

Reset
REQ-027 While reset_n=0 at a clock edge: state=IDLE, beat_cnt=0, watchdog=0, all registered outputs (rsp_data, rsp_resp, AR payload) = 0; valid/ready outputs then follow state (req_ready=1, others 0).
REQ-028 Reset mid-transaction SHALL abandon it without a response; no AR or R handshake on the first cycle after release.

Configuration
REQ-029 Macro YSYX_22041071_AXI_R_TIMEOUT_EN defined: a watchdog counts consecutive ADDR/DATA cycles without AR or R handshake, clears on each handshake, and at TIMEOUT forces RESP with rsp_resp=2'b11 keeping already-received beats; undefined: no watchdog, FSM waits indefinitely, no counter logic.

Verification
REQ-030 Single beat: addr=0x8000_0005, size=0, len=0, rdata=0x1122334455667788 -> araddr=0x8000_0000, arsize=0, rsp_data[63:0]=0x33, rsp_resp=0.
REQ-031 Burst: len=7, zero-wait slave, beats 0..7 = k+0xA0 -> arlen=7, arsize=3, rsp_data beat k = k+0xA0, rsp_valid exactly 9 cycles after AR handshake.
REQ-032 Errors: axi_r_last on beat 3 of len=7 -> rsp_resp=2'b10; req_len=8 with MAX_BEATS=8 -> no axi_ar_valid, rsp_resp=2'b10.
REQ-033 Backpressure: rsp_ready low 5 cycles -> rsp_data/rsp_resp stable, req_ready=0 throughout, req_ready=1 the cycle after rsp handshake.
REQ-034 Timeout (macro defined, TIMEOUT=16): axi_ar_ready held 0 -> RESP with rsp_resp=2'b11 after 16 ADDR cycles; macro undefined -> remains in ADDR.
REQ-035 Reset asserted during beat 2 of len=7 -> IDLE, req_ready=1, rsp_valid=0, rsp_data=0 after release.
